// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-issue MIPS core.
// Owns the PC, issues word requests to a variable-latency instruction memory
// and holds the IF/ID register feeding decode. A one-entry hold buffer keeps
// a word that lands while decode is stalled, so nothing is lost or duplicated.
// Optional performance counters are built when FETCH_PERF_EN is defined;
// otherwise fetch_cnt_o / bubble_cnt_o are tied to zero.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_valid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [5:0]        op_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  // Set while a response to a request made before a redirect is still owed
  // by memory; that response must be swallowed before a new request goes out.
  logic              r_drop;

  // IF/ID register
  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc4;

  // One-entry hold buffer for a word accepted during a stall
  logic              r_hold_vld;
  logic [31:0]       r_hold_instr;
  logic [ADDR_W-1:0] r_hold_pc4;

  logic              w_req;
  logic              w_accept;
  logic              w_redir;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_unused_lo;

  // Request is held off in REQ while a dropped response is pending, or while
  // stalled with the hold buffer already occupied (nowhere to put the word).
  assign w_req = (r_state == S_WAIT) ||
                 ((r_state == S_REQ) && !r_drop && !(stall_i && r_hold_vld));
  assign w_accept   = w_req && imem_valid_i;
  assign w_redir    = redirect_i && (r_state != S_IDLE);
  assign w_pc_next  = r_pc + ADDR_W'(4);
  assign w_redir_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  // Low address bits of the redirect target are discarded by design.
  assign w_unused_lo = ^redirect_pc_i[1:0];

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign valid_o     = r_valid;
  assign instr_o     = r_instr;
  assign op_o        = r_instr[31:26];
  assign pc4_o       = r_pc4;

  // Fetch FSM, PC, IF/ID register, hold buffer and drop flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_pc4        <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc4   <= '0;
    end else if (w_redir) begin
      // Redirect beats stall: flush IF/ID and hold, restart at the target.
      r_state    <= S_REQ;
      r_pc       <= w_redir_pc;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc4      <= '0;
      r_hold_vld <= 1'b0;
      // A request left unanswered this cycle is still owed by memory.
      r_drop     <= (w_req || r_drop) && !imem_valid_i;
    end else begin
      unique case (r_state)
        S_IDLE: if (start_i) r_state <= S_REQ;
        S_REQ: begin
          if (w_req && !imem_valid_i) r_state <= S_WAIT;
          if (r_drop && imem_valid_i) r_drop  <= 1'b0;
        end
        S_WAIT: if (imem_valid_i) r_state <= S_REQ;
        default: r_state <= S_IDLE;
      endcase

      if (w_accept) r_pc <= w_pc_next;

      if (stall_i) begin
        // IF/ID frozen; a word arriving now is parked in the hold buffer.
        if (w_accept) begin
          r_hold_vld   <= 1'b1;
          r_hold_instr <= imem_rdata_i;
          r_hold_pc4   <= w_pc_next;
        end
      end else if (r_hold_vld) begin
        // Older parked word goes first; a new arrival takes its place.
        r_valid <= 1'b1;
        r_instr <= r_hold_instr;
        r_pc4   <= r_hold_pc4;
        if (w_accept) begin
          r_hold_instr <= imem_rdata_i;
          r_hold_pc4   <= w_pc_next;
        end else begin
          r_hold_vld <= 1'b0;
        end
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_instr <= imem_rdata_i;
        r_pc4   <= w_pc_next;
      end else begin
        r_valid <= 1'b0;
        r_instr <= '0;
        r_pc4   <= '0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;
  logic        w_load_valid;
  logic        w_bubble;

  // IF/ID takes a real instruction from either the hold buffer or memory.
  assign w_load_valid = !w_redir && !stall_i && (r_hold_vld || w_accept);
  assign w_bubble     = (r_state != S_IDLE) && !r_valid && !stall_i;

  // Delivered-instruction and bubble counters, free-running and wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_load_valid) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_bubble)     r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o  = r_fetch_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`else
  assign fetch_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps followed by a randomized phase, all
// checked against an in-order instruction-stream model and a latency-driven
// memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i, start_i, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [5:0]  op_o;
  logic [31:0] pc4_o;
  logic [31:0] fetch_cnt_o, bubble_cnt_o;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .instr_o(instr_o), .op_o(op_o), .pc4_o(pc4_o),
    .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // ---------------- memory model ----------------
  bit          hash_en  = 1'b0;  // 0: word = address, 1: opcode bits vary
  bit          rand_lat = 1'b0;
  int          k_fixed  = 0;
  int          mem_k    = 0;     // latency of the next / current request
  int          mem_cnt  = 0;
  bit          mem_busy = 1'b0;
  logic [31:0] lat_addr = '0;
  logic [31:0] mem_a;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return hash_en ? (a ^ {a[7:2], 26'h0}) : a;
  endfunction

  always_comb begin
    mem_a        = mem_busy ? lat_addr : imem_addr_o;
    imem_valid_i = mem_busy ? (mem_cnt >= mem_k) : (imem_req_o && mem_k == 0);
    imem_rdata_i = hash_en ? (mem_a ^ {mem_a[7:2], 26'h0}) : mem_a;
  end

  always @(posedge clk) begin
    if (mem_busy) begin
      if (imem_valid_i) begin
        mem_busy <= 1'b0;
        mem_k    <= rand_lat ? int'($urandom_range(0, 3)) : k_fixed;
      end else mem_cnt <= mem_cnt + 1;
    end else if (imem_req_o) begin
      if (mem_k == 0) mem_k <= rand_lat ? int'($urandom_range(0, 3)) : k_fixed;
      else begin
        mem_busy <= 1'b1;
        mem_cnt  <= 1;
        lat_addr <= imem_addr_o;
      end
    end
  end

  // ---------------- stream model / checking ----------------
  int          vecs = 0, errs = 0;
  logic [31:0] exp_pc;
  int          dlv, exp_fetch, exp_bub;
  bit          running;
  logic        p_stall, p_redir, p_valid;
  logic [31:0] p_rpc, p_instr, p_pc4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample settled pre-edge state, then check post-edge state.
  task automatic step();
    logic [31:0] w;
    @(negedge clk);
    if (mem_busy && imem_req_o) chk("addr_stable", imem_addr_o, lat_addr);
    if (running && !stall_i && !valid_o) exp_bub++;
    p_stall = stall_i; p_redir = redirect_i && running; p_rpc = redirect_pc_i;
    p_valid = valid_o; p_instr = instr_o; p_pc4 = pc4_o;
    @(posedge clk); #1;
    if (!valid_o) begin
      chk("nop_instr", instr_o, 32'h0);
      chk("nop_op", 32'(op_o), 32'h0);
    end
    if (p_redir) begin
      chk("redir_bubble", 32'(valid_o), 32'h0);
      exp_pc = p_rpc & ~32'h3;
    end else if (p_stall) begin
      chk("stall_valid", 32'(valid_o), 32'(p_valid));
      chk("stall_instr", instr_o, p_instr);
      chk("stall_pc4", pc4_o, p_pc4);
    end else if (valid_o) begin
      w = memf(exp_pc);
      chk("instr", instr_o, w);
      chk("op", 32'(op_o), 32'(w[31:26]));
      chk("pc4", pc4_o, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      dlv++; exp_fetch++;
    end
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt_o, 32'(exp_fetch));
    chk("bubble_cnt", bubble_cnt_o, 32'(exp_bub));
`else
    chk("fetch_cnt_off", fetch_cnt_o, 32'h0);
    chk("bubble_cnt_off", bubble_cnt_o, 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_i = 1'b0;
    running = 1'b0; exp_pc = 32'h0; dlv = 0; exp_fetch = 0; exp_bub = 0;
  endtask

  task automatic do_start();
    start_i = 1'b1; step(); start_i = 1'b0; running = 1'b1;
  endtask

  task automatic run_until_dlv(input int target, input string tag);
    int n = 0;
    while (dlv < target && n < 60) begin step(); n++; end
    chk(tag, 32'(dlv), 32'(target));
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!mem_busy && n < 20) begin step(); n++; end
    chk(tag, 32'(mem_busy), 32'h1);
  endtask

  initial begin
    int d0;
    int n;
    redirect_pc_i = 32'h0;
    do_reset();

    // reset state
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_op", 32'(op_o), 32'h0);
    chk("rst_pc4", pc4_o, 32'h0);
    chk("rst_fcnt", fetch_cnt_o, 32'h0);
    chk("rst_bcnt", bubble_cnt_o, 32'h0);
    step();
    chk("idle_req", 32'(imem_req_o), 32'h0);

    // start latency and zero-wait sequence 0x0,0x4,0x8
    do_start();
    chk("start_req", 32'(imem_req_o), 32'h1);
    chk("start_addr", imem_addr_o, 32'h0);
    step(); chk("first_valid", 32'(valid_o), 32'h1); chk("seq0", instr_o, 32'h0);
    step(); chk("seq1", instr_o, 32'h4); chk("seq1_pc4", pc4_o, 32'h8);
    step(); chk("seq2", instr_o, 32'h8); chk("seq2_pc4", pc4_o, 32'hC);
    d0 = dlv; repeat (5) step();
    chk("tput_0wait", 32'(dlv - d0), 32'd5);

    // 2-wait memory: one instruction every three cycles
    k_fixed = 2; repeat (6) step();
    d0 = dlv; repeat (9) step();
    chk("tput_2wait", 32'(dlv - d0), 32'd3);

    // stall 3 cycles with zero-wait memory
    k_fixed = 0; repeat (6) step();
    stall_i = 1'b1; step(); step();
    chk("stall_noreq", 32'(imem_req_o), 32'h0);
    step(); stall_i = 1'b0;
    d0 = dlv; repeat (6) step();
    chk("stall_resume", 32'(dlv - d0), 32'd6);

    // redirect to 0x100 during WAIT: late response dropped
    k_fixed = 2; repeat (6) step();
    wait_busy("wait_busy_redir");
    redirect_i = 1'b1; redirect_pc_i = 32'h100; step(); redirect_i = 1'b0;
    n = 0;
    while (!valid_o && n < 20) begin step(); n++; end
    chk("redir_instr", instr_o, 32'h100);
    chk("redir_pc4", pc4_o, 32'h104);

    // redirect and stall together, misaligned target
    k_fixed = 0; repeat (6) step();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203;
    step(); stall_i = 1'b0; redirect_i = 1'b0;
    chk("rs_valid", 32'(valid_o), 32'h0);
    chk("rs_addr", imem_addr_o, 32'h200);
    chk("rs_req", 32'(imem_req_o), 32'h1);
    step(); chk("rs_instr", instr_o, 32'h200);

    // PC wrap at the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; step(); redirect_i = 1'b0;
    d0 = dlv; run_until_dlv(d0 + 2, "wrap_dlv");
    chk("wrap_instr", instr_o, 32'h0);
    chk("wrap_pc4", pc4_o, 32'h4);

    // reset mid-WAIT: late response ignored
    k_fixed = 3; repeat (8) step();
    wait_busy("wait_busy_rst");
    rst_i = 1'b1; k_fixed = 0; @(posedge clk); #1; rst_i = 1'b0;
    running = 1'b0; exp_pc = 32'h0; dlv = 0; exp_fetch = 0; exp_bub = 0;
    chk("rstw_req", 32'(imem_req_o), 32'h0);
    repeat (6) begin
      step();
      chk("rstw_valid", 32'(valid_o), 32'h0);
      chk("rstw_idle", 32'(imem_req_o), 32'h0);
    end

    // 10 instructions, 2 redirects, zero-wait: counter totals
    do_reset(); do_start();
    run_until_dlv(4, "cnt_dlv4");
    redirect_i = 1'b1; redirect_pc_i = 32'h40; step(); redirect_i = 1'b0;
    run_until_dlv(7, "cnt_dlv7");
    redirect_i = 1'b1; redirect_pc_i = 32'h80; step(); redirect_i = 1'b0;
    run_until_dlv(10, "cnt_dlv10");
`ifdef FETCH_PERF_EN
    chk("fetch10", fetch_cnt_o, 32'd10);
    chk("bubble3", bubble_cnt_o, 32'd3);
`else
    chk("fetch_off", fetch_cnt_o, 32'd0);
    chk("bubble_off", bubble_cnt_o, 32'd0);
`endif

    // randomized latency, stalls, redirects
    do_reset(); hash_en = 1'b1; rand_lat = 1'b1;
    do_start();
    for (int i = 0; i < 400; i++) begin
      stall_i    = ($urandom_range(0, 9) < 3);
      redirect_i = ($urandom_range(0, 19) == 0);
      redirect_pc_i = $urandom & 32'h0000_0FFF;
      start_i    = ($urandom_range(0, 9) == 0);
      step();
    end
    stall_i = 1'b0; redirect_i = 1'b0; start_i = 1'b0;
    d0 = dlv; repeat (20) step();
    chk("rand_progress", 32'(dlv > d0), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue MIPS core: owns the PC, issues word requests to instruction memory, and holds the IF/ID pipeline register whose opcode field (instr[31:26]) drives the main Control decoder directly. Supports stall from the hazard unit, redirect (branch/jump/flush) from ID, and variable-latency instruction memory. Invalid slots present an all-zero NOP to downstream decode.

## Interface
- ADDR_W, 32, PC/address width
- RESET_PC, 32'h0000_0000, PC value after reset

- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  leave IDLE and begin fetching; ignored when not IDLE
- stall_i  input  1  hold IF/ID and PC (load-use hazard)
- redirect_i  input  1  discard fetch path, load redirect_pc_i
- redirect_pc_i  input  ADDR_W  new PC; must be word-aligned
- imem_req_o  output  1  request valid
- imem_addr_o  output  ADDR_W  request address (current PC)
- imem_valid_i  input  1  response valid; completes the outstanding request
- imem_rdata_i  input  32  instruction word, valid when imem_valid_i
- valid_o  output  1  IF/ID holds a real instruction
- instr_o  output  32  IF/ID instruction; 32'h0 when !valid_o
- op_o  output  6  instr_o[31:26], to Control Op_i
- pc4_o  output  ADDR_W  PC+4 of the IF/ID instruction
- fetch_cnt_o  output  32  instructions delivered (see Configuration)
- bubble_cnt_o  output  32  cycles with !valid_o after start (see Configuration)

## Operation
- States: IDLE, REQ, WAIT. Reset -> IDLE.
- IDLE: imem_req_o=0. start_i -> REQ next cycle.
- REQ: imem_req_o=1, imem_addr_o=PC. If imem_valid_i same cycle, response accepted (zero-wait); else -> WAIT. Request is not issued in REQ while stall_i=1 and hold buffer full.
- WAIT: imem_req_o=1, imem_addr_o stable until imem_valid_i; then back to REQ.
- On accepted response: PC <= PC+4 (mod 2^ADDR_W, wrap silently). If !stall_i, IF/ID <= {rdata, PC+4}, valid_o=1; if stall_i, word goes into one-entry hold buffer, IF/ID unchanged.
- Stall release: hold buffer (if full) loads IF/ID first, then empties; new request resumes same cycle.
- No accepted response and !stall_i: IF/ID <= NOP, valid_o=0 (bubble).
- redirect_i: PC <= redirect_pc_i, IF/ID <= NOP, hold buffer emptied, state -> REQ. If a request is outstanding in WAIT, its response is dropped (drop flag set; next imem_valid_i ignored, then new request issued).
- Priority: rst_i > redirect_i > stall_i > normal fetch.
- Misaligned redirect_pc_i: low two bits forced to 0.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, instr_o=0, op_o=0, pc4_o=0, counters=0.
- start_i high in cycle N -> imem_req_o=1 in N+1; with zero-wait memory, valid_o=1 with first instruction in N+2.
- Zero-wait throughput: one instruction per cycle; k-wait memory: one per k+1 cycles.
- Redirect in cycle N -> bubble in N+1, request to redirect_pc_i in N+1, instruction valid in N+2 (zero-wait).
- Stall: IF/ID outputs bit-stable every stalled cycle; no instruction lost or duplicated.
- Reset mid-WAIT: state IDLE next cycle, any later imem_valid_i ignored until restarted.

## Configuration
- FETCH_PERF_EN defined: fetch_cnt_o increments each cycle IF/ID loads a valid instruction; bubble_cnt_o increments each non-IDLE cycle with valid_o=0 and !stall_i; both wrap at 2^32, cleared by rst_i.
- Undefined: counters not built, fetch_cnt_o and bubble_cnt_o tied to 0.

## Test plan
- Reset, start_i pulse, zero-wait memory with word = address -> instr_o 0x0,0x4,0x8 on consecutive cycles, pc4_o 0x4,0x8,0xC.
- 2-wait memory -> imem_addr_o stable 3 cycles per request, valid_o one cycle in three, no duplicates.
- stall_i 3 cycles while response arrives -> IF/ID frozen, buffered word delivered first after release, sequence unbroken.
- redirect_i to 0x100 during WAIT -> late response dropped, next valid instr_o from 0x100, pc4_o=0x104, exactly one bubble plus wait cycles.
- redirect_i and stall_i same cycle -> redirect wins, IF/ID = NOP, PC=target.
- With FETCH_PERF_EN, 10 instructions and 2 redirects (zero-wait) -> fetch_cnt_o=10, bubble_cnt_o=3 (start bubble + 2); without macro both 0.
